dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Request/priority stage directly upstream of the DMA timing-and-control FSM (states SI/SO/S1–S4).
- Synchronises and polarity-corrects the 4 DREQ lines and merges them with mask and software-request bits.
- Arbitrates between channels, runs the HRQ/HLDA hold handshake with the CPU, and drives DACK.
- Hands the granted channel to timing-and-control via validDREQ/channelSel and waits for its serviceDone before re-arbitrating.

Parameters:
- NUM_CH, 4, number of DMA channels; only 4 is supported, and channelSel width is fixed at 2.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  synchronous, active-high reset.
- DREQ  input  4  raw channel requests, asynchronous to CLK.
- HLDA  input  1  hold acknowledge from CPU.
- maskIn  input  4  mask register bits; 1 = channel masked.
- swReq  input  4  software request bits; bypass mask and polarity.
- priorityMode  input  1  0 = fixed priority, 1 = rotating priority.
- dreqSenseLow  input  1  1 = DREQ active-low.
- dackSenseHigh  input  1  1 = DACK active-high.
- ctrlDisable  input  1  command-register controller disable.
- serviceDone  input  1  one-cycle pulse from timing-and-control at TC/EOP/end of service.
- HRQ  output  1  hold request to CPU.
- DACK  output  4  channel acknowledges, one-hot when active.
- validDREQ  output  1  grant valid to timing-and-control.
- channelSel  output  2  encoded granted channel.

Behaviour:
- Request path:
  - DREQ passes through a 2-flop synchroniser.
  - dreqS = synchronised DREQ XOR {4{dreqSenseLow}}.
  - eff = (dreqS & ~maskIn) | swReq.
  - A DREQ edge reaches eff 2 cycles later.
- Priority, fixed mode: ch0 highest, ch3 lowest.
- Priority, rotating mode:
  - Register lowPtr (2 bits, reset 3) names the lowest-priority channel.
  - Highest priority is lowPtr+1 mod 4, with wrap 3→0.
  - After a completed service of channel n, lowPtr <= n.
- FSM states: IDLE, WAIT_HLDA, SERVICE; reset state is IDLE.
- IDLE:
  - HRQ=0, validDREQ=0, DACK inactive.
  - If eff!=0 and !ctrlDisable → WAIT_HLDA, with HRQ=1 on the next cycle.
  - IDLE lasts at least 1 cycle after any exit from SERVICE.
- WAIT_HLDA:
  - HRQ=1; the winner is re-evaluated every cycle.
  - eff==0 or ctrlDisable → IDLE, HRQ=0 next cycle.
  - HLDA==1 and eff!=0 → winner frozen into channelSel, → SERVICE.
- SERVICE:
  - HRQ=1, validDREQ=1, DACK[channelSel] active, all other DACK bits inactive.
  - Entered 1 cycle after HLDA is sampled high.
  - Changes to eff, maskIn, ctrlDisable or priorityMode are ignored while in SERVICE.
  - serviceDone → IDLE; HRQ/validDREQ/DACK deassert next cycle; lowPtr updated if priorityMode=1.
  - HLDA low while in SERVICE (abort) → IDLE, outputs deassert next cycle, lowPtr unchanged.
  - serviceDone and HLDA low in the same cycle are treated as completion.
- DACK polarity (combinational from registered one-hot dackAct):
  - DACK = dackSenseHigh ? dackAct : ~dackAct.
  - dackAct resets to 0, so DACK resets to 4'b1111 when active-low and 4'b0000 when active-high.
- Reset values: HRQ=0, validDREQ=0, channelSel=0, dackAct=0, lowPtr=3, synchroniser flops=0.
- RESET asserted mid-SERVICE: all outputs reach reset values on the next edge, with no serviceDone needed.
- serviceDone outside SERVICE: ignored.

Optional Feature:
- Macro: DMA_ROTATING_PRIORITY_EN.
- Defined: priorityMode and lowPtr behave as described above.
- Undefined: lowPtr logic is not built, priorityMode is ignored, and priority is fixed (ch0 highest).
- Ports are identical in both builds.

Test Plan:
- Fixed priority, dreqSenseLow=0, maskIn=0:
  - Stimulus: DREQ=4'b0110, HLDA raised 1 cycle after HRQ.
  - Response: HRQ=1 three cycles after the DREQ edge; channelSel=1; validDREQ=1; DACK=4'b1101 (active-low) one cycle after HLDA is sampled.
- Rotating priority (macro defined), priorityMode=1, DREQ=4'b1111 held:
  - Stimulus: serviceDone pulsed in each grant.
  - Response: grant order ch0, ch1, ch2, ch3, ch0; lowPtr=0 after the first service.
- Mask and software request, maskIn=4'b0001, swReq=0:
  - Stimulus: DREQ=4'b0001.
  - Response: HRQ stays 0.
  - Then swReq=4'b0001 → ch0 granted.
- Abort and drop:
  - Stimulus: in SERVICE on ch2, HLDA dropped.
  - Response: DACK all inactive and HRQ=0 next cycle, lowPtr unchanged.
  - Stimulus: in WAIT_HLDA, DREQ removed.
  - Response: HRQ=0 with no grant.
- Reset and disable:
  - Stimulus: RESET pulsed mid-SERVICE with dackSenseHigh=1.
  - Response: DACK=4'b0000, HRQ=0 at the next edge.
  - Stimulus: ctrlDisable=1 with DREQ=4'b1000.
  - Response: HRQ never asserts.

Source files
------------

// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the DMA priority arbiter, the CPU hold handshake
// and the timing-and-control FSM.
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [3:0] maskIn;
    logic [3:0] swReq;
    logic       priorityMode;
    logic       dreqSenseLow;
    logic       dackSenseHigh;
    logic       ctrlDisable;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       validDREQ;
    logic [1:0] channelSel;

    modport master (
        output DREQ, HLDA, maskIn, swReq, priorityMode, dreqSenseLow,
               dackSenseHigh, ctrlDisable, serviceDone,
        input  HRQ, DACK, validDREQ, channelSel
    );

    modport slave (
        input  DREQ, HLDA, maskIn, swReq, priorityMode, dreqSenseLow,
               dackSenseHigh, ctrlDisable, serviceDone,
        output HRQ, DACK, validDREQ, channelSel
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA request synchroniser, channel arbiter and HRQ/HLDA hold handshake.
// Define DMA_ROTATING_PRIORITY_EN to build rotating priority (lowPtr); otherwise fixed ch0-first.
module dma_priority_arbiter #(
    parameter int unsigned NUM_CH = 4
) (
    input logic                 CLK,
    input logic                 RESET,
    dma_priority_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HLDA,
        SERVICE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] dreq_s;
    logic [NUM_CH-1:0] eff;
    logic [NUM_CH-1:0] dack_act;
    logic [1:0]        channel_sel;
    logic [1:0]        winner;
    logic [1:0]        fixed_winner;
    logic              grant;
    logic              complete;
    logic              leave_service;

    assign dreq_s = sync2 ^ {NUM_CH{bus.dreqSenseLow}};
    assign eff    = (dreq_s & ~bus.maskIn) | bus.swReq;

    // Descending scan so the lowest requesting index wins.
    always_comb begin
        fixed_winner = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (eff[NUM_CH-1-i]) begin
                fixed_winner = 2'(NUM_CH-1-i);
            end
        end
    end

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [1:0] low_ptr;
    logic [1:0] rot_winner;
    logic [1:0] idx;
    logic       found;
    logic       mode_q;

    // Search starts just above the lowest-priority channel and wraps 3 -> 0.
    always_comb begin
        rot_winner = '0;
        idx        = '0;
        found      = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = low_ptr + 2'd1 + k[1:0];
            if (!found && eff[idx]) begin
                rot_winner = idx;
                found      = 1'b1;
            end
        end
    end

    assign winner = bus.priorityMode ? rot_winner : fixed_winner;

    // Mode is captured at grant so a mid-service change cannot affect the pointer update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            low_ptr <= 2'd3;
            mode_q  <= 1'b0;
        end else begin
            if (grant) begin
                mode_q <= bus.priorityMode;
            end
            if (complete && mode_q) begin
                low_ptr <= channel_sel;
            end
        end
    end
`else
    logic unused_priority_mode;

    assign unused_priority_mode = bus.priorityMode;
    assign winner               = fixed_winner;
`endif

    always_comb begin
        state_next    = state;
        grant         = 1'b0;
        complete      = 1'b0;
        leave_service = 1'b0;
        case (state)
            IDLE: begin
                if ((eff != '0) && !bus.ctrlDisable) begin
                    state_next = WAIT_HLDA;
                end
            end
            WAIT_HLDA: begin
                if ((eff == '0) || bus.ctrlDisable) begin
                    state_next = IDLE;
                end else if (bus.HLDA) begin
                    grant      = 1'b1;
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                // serviceDone takes precedence over a simultaneous HLDA drop.
                if (bus.serviceDone) begin
                    complete      = 1'b1;
                    leave_service = 1'b1;
                    state_next    = IDLE;
                end else if (!bus.HLDA) begin
                    leave_service = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            sync1       <= '0;
            sync2       <= '0;
            channel_sel <= '0;
            dack_act    <= '0;
        end else begin
            state <= state_next;
            sync1 <= bus.DREQ;
            sync2 <= sync1;
            if (grant) begin
                channel_sel <= winner;
                dack_act    <= NUM_CH'(1) << winner;
            end else if (leave_service) begin
                dack_act <= '0;
            end
        end
    end

    assign bus.HRQ        = (state != IDLE);
    assign bus.validDREQ  = (state == SERVICE);
    assign bus.channelSel = channel_sel;
    assign bus.DACK       = bus.dackSenseHigh ? dack_act : ~dack_act;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter; expected grants are queued when requests
// are driven and popped when the arbiter presents validDREQ.
module tb_dma_priority_arbiter;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    dma_priority_arbiter_if bus ();

    dma_priority_arbiter #(.NUM_CH(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;
    int unsigned exp_q[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dack_exp(input int unsigned ch);
        logic [3:0] a;
        a = 4'b0001 << ch;
        return bus.dackSenseHigh ? a : ~a;
    endfunction

    function automatic logic [3:0] dack_idle();
        return bus.dackSenseHigh ? 4'b0000 : 4'b1111;
    endfunction

    // Acts as the CPU: raise HLDA once HRQ is seen, then wait for the grant.
    task automatic serve(input string tag);
        bit          got;
        int unsigned ch;
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.HRQ) bus.HLDA = 1'b1;
            if (bus.validDREQ) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, {3'b000, bus.validDREQ}, 4'b0001);
        end else if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, {2'b00, bus.channelSel}, 4'b1111);
        end else begin
            ch = exp_q.pop_front();
            check({tag, "_sel"}, {2'b00, bus.channelSel}, 4'(ch));
            check({tag, "_dack"}, bus.DACK, dack_exp(ch));
        end
    endtask

    task automatic done_pulse(input string tag);
        bus.serviceDone = 1'b1;
        tick();
        bus.serviceDone = 1'b0;
        check({tag, "_done_valid"}, {3'b000, bus.validDREQ}, 4'b0000);
        check({tag, "_done_dack"}, bus.DACK, dack_idle());
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic quiesce();
        bus.DREQ  = 4'b0000;
        bus.HLDA  = 1'b0;
        bus.swReq = 4'b0000;
        repeat (5) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET             = 1'b1;
        bus.DREQ          = 4'b0000;
        bus.HLDA          = 1'b0;
        bus.maskIn        = 4'b0000;
        bus.swReq         = 4'b0000;
        bus.priorityMode  = 1'b0;
        bus.dreqSenseLow  = 1'b0;
        bus.dackSenseHigh = 1'b0;
        bus.ctrlDisable   = 1'b0;
        bus.serviceDone   = 1'b0;
        tick();
        tick();
        check("rst_hrq", {3'b000, bus.HRQ}, 4'b0000);
        check("rst_valid", {3'b000, bus.validDREQ}, 4'b0000);
        check("rst_dack", bus.DACK, 4'b1111);
        check("rst_sel", {2'b00, bus.channelSel}, 4'b0000);
        RESET = 1'b0;
        tick();

        // Fixed priority: DREQ edge to HRQ latency, then ch1 wins over ch2.
        bus.DREQ = 4'b0110;
        tick();
        check("fix_hrq_c1", {3'b000, bus.HRQ}, 4'b0000);
        tick();
        check("fix_hrq_c2", {3'b000, bus.HRQ}, 4'b0000);
        tick();
        check("fix_hrq_c3", {3'b000, bus.HRQ}, 4'b0001);
        bus.HLDA = 1'b1;
        exp_q.push_back(1);
        tick();
        check("fix_valid", {3'b000, bus.validDREQ}, 4'b0001);
        check("fix_sel", {2'b00, bus.channelSel}, 4'(exp_q.pop_front()));
        check("fix_dack", bus.DACK, 4'b1101);
        done_pulse("fix");
        check("fix_done_hrq", {3'b000, bus.HRQ}, 4'b0000);
        quiesce();

        // All channels requesting with rotating mode selected.
        pulse_reset();
        bus.priorityMode = 1'b1;
        bus.DREQ = 4'b1111;
`ifdef DMA_ROTATING_PRIORITY_EN
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
`else
        repeat (5) exp_q.push_back(0);
`endif
        for (int i = 0; i < 5; i++) begin
            serve("rot");
            done_pulse("rot");
        end
        quiesce();

        // Masked hardware request is ignored; software request bypasses the mask.
        bus.maskIn = 4'b0001;
        bus.DREQ   = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mask_hrq", {3'b000, bus.HRQ}, 4'b0000);
        end
        bus.swReq = 4'b0001;
        exp_q.push_back(0);
        serve("sw");
        done_pulse("sw");
        bus.swReq  = 4'b0000;
        bus.maskIn = 4'b0000;
        quiesce();

        // Abort on ch2, then confirm priority pointer was not advanced.
        pulse_reset();
        bus.DREQ = 4'b0100;
        exp_q.push_back(2);
        serve("abort_grant");
        bus.HLDA = 1'b0;
        tick();
        check("abort_dack", bus.DACK, 4'b1111);
        check("abort_hrq", {3'b000, bus.HRQ}, 4'b0000);
        check("abort_valid", {3'b000, bus.validDREQ}, 4'b0000);
        bus.DREQ = 4'b1111;
        repeat (3) tick();
        exp_q.push_back(0);
        serve("post_abort");
        done_pulse("post_abort");
        quiesce();

        // Request withdrawn while waiting for HLDA.
        bus.DREQ = 4'b1000;
        repeat (3) tick();
        check("drop_hrq_up", {3'b000, bus.HRQ}, 4'b0001);
        bus.DREQ = 4'b0000;
        repeat (2) tick();
        check("drop_hrq_hold", {3'b000, bus.HRQ}, 4'b0001);
        tick();
        check("drop_hrq_down", {3'b000, bus.HRQ}, 4'b0000);
        check("drop_valid", {3'b000, bus.validDREQ}, 4'b0000);
        quiesce();

        // Reset in the middle of a service with active-high DACK.
        bus.dackSenseHigh = 1'b1;
        bus.DREQ = 4'b1000;
        exp_q.push_back(3);
        serve("rstsvc_grant");
        RESET = 1'b1;
        tick();
        check("rstsvc_dack", bus.DACK, 4'b0000);
        check("rstsvc_hrq", {3'b000, bus.HRQ}, 4'b0000);
        check("rstsvc_valid", {3'b000, bus.validDREQ}, 4'b0000);
        check("rstsvc_sel", {2'b00, bus.channelSel}, 4'b0000);
        RESET    = 1'b0;
        bus.HLDA = 1'b0;

        // Controller disabled: a held request never raises HRQ.
        bus.ctrlDisable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("dis_hrq", {3'b000, bus.HRQ}, 4'b0000);
        end
        bus.ctrlDisable = 1'b0;
        tick();
        check("enable_hrq", {3'b000, bus.HRQ}, 4'b0001);
        quiesce();

        check("queue_empty", 4'(exp_q.size()), 4'b0000);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
